// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 block geometry and converter state type
package sha_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;
    localparam int BLOCK_W   = NUM_WORDS * WORD_W;

    typedef enum logic {
        IDLE,
        SHIFT
    } pts_state_t;

endpackage

// File: rtl/pts_sr_16_if.sv
// rtl/pts_sr_16_if.sv - block load handshake and word stream bundle
// Signals:
//   load_valid/load_ready/parallel_in : block load handshake (env -> converter)
//   out_valid/out_ready/serial_out    : word stream (converter -> env)
//   out_index/out_last                : position of the word in flight
// Modports: master = surrounding environment, slave = converter.
interface pts_sr_16_if #(
    parameter int NUM_WORDS = sha_pkg::NUM_WORDS,
    parameter int WORD_W    = sha_pkg::WORD_W
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic                        load_valid;
    logic                        load_ready;
    logic [NUM_WORDS*WORD_W-1:0] parallel_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [WORD_W-1:0]           serial_out;
    logic [IDX_W-1:0]            out_index;
    logic                        out_last;

    modport master (
        output load_valid, parallel_in, out_ready,
        input  load_ready, out_valid, serial_out, out_index, out_last
    );

    modport slave (
        input  load_valid, parallel_in, out_ready,
        output load_ready, out_valid, serial_out, out_index, out_last
    );
endinterface

// File: rtl/pts_sr.sv
// rtl/pts_sr.sv - generic word-wide parallel-load / shift-out register
// Ports:
//   clk, n_rst   : clock, asynchronous active-low reset (clears all slots)
//   load         : capture parallel_in[k] into slot k (wins over shift_en)
//   shift_en     : move slot k to slot k+1, slot 0 fills with zero
//   parallel_in  : one word per slot
//   serial_out   : top slot (NUM_WORDS-1)
module pts_sr #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] parallel_in [NUM_WORDS],
    output logic [WORD_W-1:0] serial_out
);
    logic [WORD_W-1:0] slot_q [NUM_WORDS];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_WORDS; k++) slot_q[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_WORDS; k++) slot_q[k] <= parallel_in[k];
        end else if (shift_en) begin
            slot_q[0] <= '0;
            for (int k = 1; k < NUM_WORDS; k++) slot_q[k] <= slot_q[k-1];
        end
    end

    assign serial_out = slot_q[NUM_WORDS-1];
endmodule

// File: rtl/pts_sr_16.sv
// rtl/pts_sr_16.sv - 512-bit block to 16 x 32-bit word stream, top word first
// Ports:
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   clear  : synchronous abort, drops the block in flight
//   bus    : slave side of pts_sr_16_if (load handshake + word stream)
module pts_sr_16 #(
    parameter int NUM_WORDS = sha_pkg::NUM_WORDS,
    parameter int WORD_W    = sha_pkg::WORD_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    pts_sr_16_if.slave   bus
);
    import sha_pkg::*;

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    pts_state_t        state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              out_valid;
    logic              out_last;
    logic              beat;
    logic              load_ready;
    logic              capture;
    logic              shift_en;
    logic [WORD_W-1:0] words [NUM_WORDS];

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_unpack
        assign words[k] = bus.parallel_in[k*WORD_W +: WORD_W];
    end

    assign out_valid = (state_q == SHIFT);
    assign out_last  = out_valid && (count_q == LAST_IDX);
    assign beat      = out_valid && bus.out_ready;

    // A new block may enter while idle, or on the beat that retires the last
    // word so consecutive blocks run without a bubble. This is the only
    // combinational input-to-output path (via out_ready).
    assign load_ready = !clear && (!out_valid || (beat && out_last));
    assign capture    = bus.load_valid && load_ready;
    assign shift_en   = beat && !out_last && !clear;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (capture) begin
            state_d = SHIFT;
            count_d = '0;
        end else if (beat) begin
            if (out_last) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                count_d = count_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    pts_sr #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .load        (capture),
        .shift_en    (shift_en),
        .parallel_in (words),
        .serial_out  (bus.serial_out)
    );

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_index  = count_q;
    assign bus.out_last   = out_last;
endmodule

// File: tb/tb_pts_sr_16.sv
// tb/tb_pts_sr_16.sv - directed self-checking bench for pts_sr_16
module tb_pts_sr_16;

    logic clk;
    logic n_rst;
    logic clear;
    int   checks;
    int   errors;

    pts_sr_16_if #(.NUM_WORDS(16), .WORD_W(32)) bus ();

    pts_sr_16 #(.NUM_WORDS(16), .WORD_W(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_block(input logic [31:0] base);
        for (int k = 0; k < 16; k++) bus.parallel_in[k*32 +: 32] = base + 32'(k);
    endtask

    task automatic test_reset;
        #12;
        checks += 5;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %b want 1", bus.load_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        if (bus.serial_out !== 32'h0) begin errors++; $display("FAIL rst_serial_out got %h want 0", bus.serial_out); end
        if (bus.out_index !== 4'd0) begin errors++; $display("FAIL rst_out_index got %0d want 0", bus.out_index); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        set_block(32'h1000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b1;
        #2;
        checks += 2;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b want 1", bus.load_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b want 0", bus.out_valid); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
            #2;
            checks += 5;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b want 1", i, bus.out_valid); end
            if (bus.serial_out !== 32'h1000_000F - 32'(i)) begin errors++; $display("FAIL single_word[%0d] got %h want %h", i, bus.serial_out, 32'h1000_000F - 32'(i)); end
            if (bus.out_index !== 4'(i)) begin errors++; $display("FAIL single_index[%0d] got %0d want %0d", i, bus.out_index, i); end
            if (bus.out_last !== (i == 15)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", i, bus.out_last, (i == 15)); end
            if (bus.load_ready !== (i == 15)) begin errors++; $display("FAIL single_load_ready[%0d] got %b want %b", i, bus.load_ready, (i == 15)); end
        end
        @(posedge clk); #3;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b want 0", bus.out_valid); end
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready got %b want 1", bus.load_ready); end
    endtask

    task automatic test_backpressure;
        int beats;
        int cyc;
        @(posedge clk); #1;
        set_block(32'h1000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 16 && cyc < 400) begin
            bus.out_ready = ($urandom_range(0, 99) < 30);
            #2;
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", beats, bus.out_valid); end
            if (bus.serial_out !== 32'h1000_000F - 32'(beats)) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", beats, bus.serial_out, 32'h1000_000F - 32'(beats)); end
            if (bus.out_index !== 4'(beats)) begin errors++; $display("FAIL bp_index[%0d] got %0d want %0d", beats, bus.out_index, beats); end
            if (bus.out_ready) beats++;
            @(posedge clk); #1;
            cyc++;
        end
        checks += 2;
        if (beats != 16) begin errors++; $display("FAIL bp_timeout beats %0d want 16", beats); end
        #2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        set_block(32'h1000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            set_block(32'hA5A5_0000); bus.load_valid = 1'b1;
            #2;
            checks += 3;
            if (bus.serial_out !== 32'h1000_000F - 32'(i)) begin errors++; $display("FAIL b2b_first_word[%0d] got %h want %h", i, bus.serial_out, 32'h1000_000F - 32'(i)); end
            if (bus.out_index !== 4'(i)) begin errors++; $display("FAIL b2b_first_index[%0d] got %0d want %0d", i, bus.out_index, i); end
            if (bus.load_ready !== (i == 15)) begin errors++; $display("FAIL b2b_load_ready[%0d] got %b want %b", i, bus.load_ready, (i == 15)); end
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
            #2;
            checks += 4;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid[%0d] got %b want 1", i, bus.out_valid); end
            if (bus.serial_out !== 32'hA5A5_000F - 32'(i)) begin errors++; $display("FAIL b2b_second_word[%0d] got %h want %h", i, bus.serial_out, 32'hA5A5_000F - 32'(i)); end
            if (bus.out_index !== 4'(i)) begin errors++; $display("FAIL b2b_second_index[%0d] got %0d want %0d", i, bus.out_index, i); end
            if (bus.out_last !== (i == 15)) begin errors++; $display("FAIL b2b_second_last[%0d] got %b want %b", i, bus.out_last, (i == 15)); end
        end
        @(posedge clk); #3;
        checks += 1;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_clear;
        @(posedge clk); #1;
        set_block(32'h1000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
            #2;
            checks += 1;
            if (bus.serial_out !== 32'h1000_000F - 32'(i)) begin errors++; $display("FAIL clr_word[%0d] got %h want %h", i, bus.serial_out, 32'h1000_000F - 32'(i)); end
        end
        @(posedge clk); #1;
        clear = 1'b1; set_block(32'h2000_0000); bus.load_valid = 1'b1;
        #2;
        checks += 2;
        if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL clr_load_ready got %b want 0", bus.load_ready); end
        if (bus.out_index !== 4'd5) begin errors++; $display("FAIL clr_pre_index got %0d want 5", bus.out_index); end
        @(posedge clk); #1;
        clear = 1'b0; bus.load_valid = 1'b0;
        #2;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", bus.out_valid); end
        if (bus.out_index !== 4'd0) begin errors++; $display("FAIL clr_index got %0d want 0", bus.out_index); end
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL clr_idle_ready got %b want 1", bus.load_ready); end
        @(posedge clk); #1;
        set_block(32'h2000_0000); bus.load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
            #2;
            checks += 2;
            if (bus.serial_out !== 32'h2000_000F - 32'(i)) begin errors++; $display("FAIL clr_restart_word[%0d] got %h want %h", i, bus.serial_out, 32'h2000_000F - 32'(i)); end
            if (bus.out_index !== 4'(i)) begin errors++; $display("FAIL clr_restart_index[%0d] got %0d want %0d", i, bus.out_index, i); end
        end
        @(posedge clk); #3;
        checks += 1;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_end_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_load_ignored;
        @(posedge clk); #1;
        set_block(32'h3000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.load_valid = (i == 7);
            if (i == 7) set_block(32'hA5A5_0000);
            #2;
            checks += 2;
            if (bus.serial_out !== 32'h3000_000F - 32'(i)) begin errors++; $display("FAIL ign_word[%0d] got %h want %h", i, bus.serial_out, 32'h3000_000F - 32'(i)); end
            if (bus.out_index !== 4'(i)) begin errors++; $display("FAIL ign_index[%0d] got %0d want %0d", i, bus.out_index, i); end
            if (i == 7) begin
                checks += 1;
                if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL ign_load_ready got %b want 0", bus.load_ready); end
            end
        end
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        #2;
        checks += 1;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ign_end_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        set_block(32'h4000_0000); bus.load_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.load_valid = 1'b0;
        end
        #1;
        n_rst = 1'b0;
        #1;
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.load_ready); end
        if (bus.out_index !== 4'd0) begin errors++; $display("FAIL rstmid_index got %0d want 0", bus.out_index); end
        if (bus.serial_out !== 32'h0) begin errors++; $display("FAIL rstmid_word got %h want 0", bus.serial_out); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b want 0", bus.out_last); end
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            checks += 1;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid[%0d] got %b want 0", i, bus.out_valid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst = 1'b0;
        clear = 1'b0;
        bus.load_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.parallel_in = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_load_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
